// File: rtl/calc_pkg.sv
// calc_pkg: state encoding, keypad character codes and key classifiers
// shared by the calculator engine and its divider.
// Build option: define CALC_DIV_EN to enable '/' and the iterative divider.
package calc_pkg;

  typedef enum logic [2:0] {
    S_A   = 3'd0,
    S_B   = 3'd1,
    S_DIV = 3'd2,
    S_RES = 3'd3,
    S_ERR = 3'd4
  } calc_state_e;

  localparam logic [7:0] CH_PLUS  = 8'h2B;  // '+'
  localparam logic [7:0] CH_MINUS = 8'h2D;  // '-'
  localparam logic [7:0] CH_MUL   = 8'h2A;  // '*'
  localparam logic [7:0] CH_DIV   = 8'h2F;  // '/'
  localparam logic [7:0] CH_EQ    = 8'h3D;  // '='
  localparam logic [7:0] CH_CLR   = 8'h43;  // 'C'
  localparam logic [7:0] CH_0     = 8'h30;  // '0'
  localparam logic [7:0] CH_9     = 8'h39;  // '9'

`ifdef CALC_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= CH_0) && (c <= CH_9);
  endfunction

  // '/' only counts as an operator when the divider is built in; otherwise
  // it falls through as an unrecognised key and is ignored everywhere.
  function automatic logic is_op(input logic [7:0] c);
    return (c == CH_PLUS) || (c == CH_MINUS) || (c == CH_MUL) ||
           (DIV_EN && (c == CH_DIV));
  endfunction

endpackage

// File: rtl/calc_divider.sv
// calc_divider: W-bit unsigned restoring divider, one quotient bit per cycle.
// The first step is taken in the same cycle as start, so done is a one-cycle
// pulse in the W-th cycle after start, with quotient already final.
// Only instantiated when CALC_DIV_EN is defined.
module calc_divider #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] quotient
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  rem_q, quo_q, dvs_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  rem_in, quo_in, dvs_in, rem_nx, quo_nx;
  logic [W+1:0]  trial;

  // One restoring step, on fresh operands when starting, else on held state
  always_comb begin
    rem_in = start ? '0       : rem_q;
    quo_in = start ? dividend : quo_q;
    dvs_in = start ? divisor  : dvs_q;
    trial  = {1'b0, rem_in, quo_in[W-1]} - {2'b00, dvs_in};
    // Non-negative trial is always below the divisor, so bit W is zero then
    if (|trial[W+1:W]) begin
      rem_nx = {rem_in[W-2:0], quo_in[W-1]};
      quo_nx = {quo_in[W-2:0], 1'b0};
    end else begin
      rem_nx = trial[W-1:0];
      quo_nx = {quo_in[W-2:0], 1'b1};
    end
  end

  // Iteration registers: load-and-step on start, then count down the rest
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      done  <= 1'b0;
    end else if (start) begin
      rem_q <= rem_nx;
      quo_q <= quo_nx;
      dvs_q <= divisor;
      cnt_q <= CW'(W - 1);
      done  <= (W == 1);
    end else if (cnt_q != '0) begin
      rem_q <= rem_nx;
      quo_q <= quo_nx;
      cnt_q <= cnt_q - 1'b1;
      done  <= (cnt_q == CW'(1));
    end else begin
      done  <= 1'b0;
    end
  end

  assign quotient = quo_q;

endmodule

// File: rtl/calc_engine.sv
// calc_engine: multi-digit four-function calculator between the keypad
// decoder and the display driver. Results can seed the next expression;
// overflow, negative results and divide-by-zero latch a sticky error.
// Build option: CALC_DIV_EN adds '/', the S_DIV state and calc_divider.
//
// Key handshake: btn_valid is a one-cycle strobe qualifying btn_char; there
// is no backpressure. A key is taken when btn_valid=1 and (busy=0 or the key
// is 'C'); any other strobe is dropped and leaves every output unchanged.
module calc_engine
  import calc_pkg::*;
#(
  parameter int W          = 16,
  parameter int MAX_DIGITS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         btn_valid,
  input  logic [7:0]   btn_char,
  output logic         busy,
  output logic [7:0]   disp_char0,
  output logic [7:0]   disp_char1,
  output logic [7:0]   op_char,
  output logic [W-1:0] entry_val,
  output logic [W-1:0] result_value,
  output logic         result_valid,
  output logic         error
);

  localparam int CW = $clog2(MAX_DIGITS + 1);

  calc_state_e     state_q, state_d;
  logic [W-1:0]    acc_q, acc_d, a_q, a_d, res_q, res_d;
  logic [CW-1:0]   ndig_q, ndig_d;
  logic [7:0]      d0_q, d0_d, d1_q, d1_d, op_q, op_d;
  logic            rv_q, rv_d, err_q, err_d;

  logic            accept, is_clr, key_digit, key_op, room, shift;
  logic [W-1:0]    digit_val, acc_push;
  logic [2*W-1:0]  a_wide, b_wide, sum_wide, prod_wide;
  logic            div_start, div_done;
  logic [W-1:0]    div_quo;

  assign is_clr    = (btn_char == CH_CLR);
  assign key_digit = is_digit(btn_char);
  assign key_op    = is_op(btn_char);
  assign accept    = btn_valid && (!busy || is_clr);
  assign room      = (ndig_q < CW'(MAX_DIGITS));
  assign digit_val = W'(btn_char - CH_0);
  assign acc_push  = acc_q * 4'd10 + digit_val;

  // Operands widened so overflow is visible in the upper half
  assign a_wide    = {{W{1'b0}}, a_q};
  assign b_wide    = {{W{1'b0}}, acc_q};
  assign sum_wide  = a_wide + b_wide;
  assign prod_wide = a_wide * b_wide;

  // Next-state and register updates for every accepted key and division end
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    a_d       = a_q;
    res_d     = res_q;
    ndig_d    = ndig_q;
    op_d      = op_q;
    d0_d      = d0_q;
    d1_d      = d1_q;
    rv_d      = 1'b0;
    err_d     = err_q;
    div_start = 1'b0;
    shift     = 1'b0;

    if (accept && is_clr) begin
      state_d = S_A;
      acc_d   = '0;
      a_d     = '0;
      res_d   = '0;
      ndig_d  = '0;
      op_d    = '0;
      d0_d    = '0;
      d1_d    = '0;
      err_d   = 1'b0;
    end else if (state_q == S_DIV) begin
      if (div_done) begin
        res_d   = div_quo;
        rv_d    = 1'b1;
        state_d = S_RES;
      end
    end else if (accept) begin
      case (state_q)
        S_A, S_B: begin
          if (key_digit) begin
            if (room) begin
              acc_d  = acc_push;
              ndig_d = ndig_q + 1'b1;
              shift  = 1'b1;
            end
          end else if (key_op) begin
            if (state_q == S_A && ndig_q != '0) begin
              a_d     = acc_q;
              op_d    = btn_char;
              acc_d   = '0;
              ndig_d  = '0;
              state_d = S_B;
              shift   = 1'b1;
            end else if (state_q == S_B && ndig_q == '0) begin
              op_d  = btn_char;
              shift = 1'b1;
            end
          end else if (btn_char == CH_EQ && state_q == S_B && ndig_q != '0) begin
            shift   = 1'b1;
            acc_d   = '0;
            ndig_d  = '0;
            state_d = S_RES;
            rv_d    = 1'b1;
            case (op_q)
              CH_PLUS: begin
                if (|sum_wide[2*W-1:W]) err_d = 1'b1;
                else res_d = sum_wide[W-1:0];
              end
              CH_MINUS: begin
                if (a_q < acc_q) err_d = 1'b1;
                else res_d = a_q - acc_q;
              end
              CH_MUL: begin
                if (|prod_wide[2*W-1:W]) err_d = 1'b1;
                else res_d = prod_wide[W-1:0];
              end
              default: begin
                // Division: a zero divisor fails at once, never starting
                if (acc_q == '0) begin
                  err_d = 1'b1;
                end else begin
                  div_start = 1'b1;
                  rv_d      = 1'b0;
                  state_d   = S_DIV;
                end
              end
            endcase
            if (err_d) begin
              res_d   = '0;
              state_d = S_ERR;
            end
          end
        end
        S_RES: begin
          if (key_digit) begin
            acc_d   = digit_val;
            ndig_d  = CW'(1);
            op_d    = '0;
            state_d = S_A;
            shift   = 1'b1;
          end else if (key_op) begin
            a_d     = res_q;
            op_d    = btn_char;
            acc_d   = '0;
            ndig_d  = '0;
            state_d = S_B;
            shift   = 1'b1;
          end
        end
        default: ;  // S_ERR: only 'C', handled above
      endcase
    end

    if (shift) begin
      d1_d = d0_q;
      d0_d = btn_char;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_A;
      acc_q   <= '0;
      a_q     <= '0;
      res_q   <= '0;
      ndig_q  <= '0;
      op_q    <= '0;
      d0_q    <= '0;
      d1_q    <= '0;
      rv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      res_q   <= res_d;
      ndig_q  <= ndig_d;
      op_q    <= op_d;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
      rv_q    <= rv_d;
      err_q   <= err_d;
    end
  end

`ifdef CALC_DIV_EN
  assign busy = (state_q == S_DIV);

  calc_divider #(.W(W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (a_q),
    .divisor  (acc_q),
    .done     (div_done),
    .quotient (div_quo)
  );
`else
  logic unused_div_start;
  assign unused_div_start = div_start;
  assign busy             = 1'b0;
  assign div_done         = 1'b0;
  assign div_quo          = '0;
`endif

  assign disp_char0   = d0_q;
  assign disp_char1   = d1_q;
  assign op_char      = op_q;
  assign entry_val    = (state_q == S_RES) ? res_q : acc_q;
  assign result_value = res_q;
  assign result_valid = rv_q;
  assign error        = err_q;

endmodule

// File: tb/tb_calc_engine.sv
// tb_calc_engine: directed scenarios plus a randomized key stream checked
// against an integer-arithmetic calculator model. Works with and without
// CALC_DIV_EN.
module tb_calc_engine;

  localparam int W = 16;
`ifdef CALC_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         btn_valid = 1'b0;
  logic [7:0]   btn_char = 8'h00;
  logic         busy, result_valid, error;
  logic [7:0]   disp_char0, disp_char1, op_char;
  logic [W-1:0] entry_val, result_value;

  int n_vec = 0;
  int n_err = 0;

  calc_engine #(.W(W), .MAX_DIGITS(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_valid    (btn_valid),
    .btn_char     (btn_char),
    .busy         (busy),
    .disp_char0   (disp_char0),
    .disp_char1   (disp_char1),
    .op_char      (op_char),
    .entry_val    (entry_val),
    .result_value (result_value),
    .result_valid (result_valid),
    .error        (error)
  );

  // clock
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  // One key: strobe for one cycle; returns at the falling edge after the
  // accepting rising edge, where registered effects are already visible.
  task automatic key(input logic [7:0] ch);
    @(negedge clk);
    btn_valid = 1'b1;
    btn_char  = ch;
    @(negedge clk);
    btn_valid = 1'b0;
    btn_char  = 8'h00;
  endtask

  task automatic keys(input string s);
    for (int i = 0; i < s.len(); i++) key(s[i]);
  endtask

  // ---------------- reference model ----------------
  int         m_acc, m_nd, m_a, m_res;
  logic [7:0] m_op, m_d0, m_d1;
  bit         m_err, m_in_b, m_in_res, m_rv, m_div;

  function automatic void model_clear();
    m_acc = 0; m_nd = 0; m_a = 0; m_res = 0;
    m_op = 0; m_d0 = 0; m_d1 = 0;
    m_err = 0; m_in_b = 0; m_in_res = 0; m_rv = 0; m_div = 0;
  endfunction

  function automatic void model_key(input logic [7:0] ch);
    bit     dig, op, eff, bad;
    longint a, b, r;
    dig = (ch >= "0") && (ch <= "9");
    op  = (ch == "+") || (ch == "-") || (ch == "*") || (DIV_ON && ch == "/");
    eff = 0; bad = 0; r = 0;
    m_rv = 0; m_div = 0;
    if (ch == "C") begin model_clear(); return; end
    if (m_err) return;
    if (m_in_res) begin
      if (dig) begin
        m_acc = int'(ch - "0"); m_nd = 1; m_op = 0; m_in_res = 0; m_in_b = 0; eff = 1;
      end else if (op) begin
        m_a = m_res; m_op = ch; m_acc = 0; m_nd = 0; m_in_res = 0; m_in_b = 1; eff = 1;
      end
    end else if (dig) begin
      if (m_nd < 4) begin m_acc = m_acc * 10 + int'(ch - "0"); m_nd++; eff = 1; end
    end else if (op) begin
      if (!m_in_b && m_nd > 0) begin
        m_a = m_acc; m_op = ch; m_acc = 0; m_nd = 0; m_in_b = 1; eff = 1;
      end else if (m_in_b && m_nd == 0) begin
        m_op = ch; eff = 1;
      end
    end else if (ch == "=" && m_in_b && m_nd > 0) begin
      eff = 1; a = m_a; b = m_acc;
      m_acc = 0; m_nd = 0; m_in_b = 0;
      case (m_op)
        "+": r = a + b;
        "-": r = a - b;
        "*": r = a * b;
        default: if (b == 0) bad = 1; else r = a / b;
      endcase
      if (r < 0 || r > 65535) bad = 1;
      if (bad) begin
        m_err = 1; m_res = 0; m_rv = 1;
      end else begin
        m_res = int'(r); m_in_res = 1;
        if (m_op == "/") m_div = 1; else m_rv = 1;
      end
    end
    if (eff) begin m_d1 = m_d0; m_d0 = ch; end
  endfunction

  function automatic logic [7:0] rand_key();
    int r;
    r = $urandom_range(0, 99);
    if (r < 50) return 8'(8'h30 + $urandom_range(0, 9));
    if (r < 75) begin
      case ($urandom_range(0, 3))
        0: return "+";
        1: return "-";
        2: return "*";
        default: return "/";
      endcase
    end
    if (r < 90) return "=";
    if (r < 95) return "C";
    return ($urandom_range(0, 1) != 0) ? "x" : ".";
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (disp_char0 !== 8'h00 || disp_char1 !== 8'h00) begin n_err++; $display("FAIL reset_disp: got %h %h want 00 00", disp_char0, disp_char1); end
    n_vec++; if (op_char !== 8'h00) begin n_err++; $display("FAIL reset_op: got %h want 00", op_char); end
    n_vec++; if (entry_val !== '0 || result_value !== '0) begin n_err++; $display("FAIL reset_vals: got %0d %0d want 0 0", entry_val, result_value); end
    n_vec++; if (result_valid !== 1'b0 || error !== 1'b0) begin n_err++; $display("FAIL reset_flags: got rv=%b err=%b want 0 0", result_valid, error); end
    rst = 1'b0;
  endtask

  task automatic test_add();
    keys("12+");
    n_vec++; if (op_char !== "+" || entry_val !== 16'd0) begin n_err++; $display("FAIL add_op: got op=%h entry=%0d want 2b 0", op_char, entry_val); end
    keys("34");
    n_vec++; if (entry_val !== 16'd34) begin n_err++; $display("FAIL add_entry: got %0d want 34", entry_val); end
    n_vec++; if (disp_char0 !== "4" || disp_char1 !== "3") begin n_err++; $display("FAIL add_disp: got %h %h want 34 33", disp_char0, disp_char1); end
    key("=");
    n_vec++; if (result_valid !== 1'b1 || result_value !== 16'd46 || error !== 1'b0) begin n_err++; $display("FAIL add_result: got rv=%b val=%0d err=%b want 1 46 0", result_valid, result_value, error); end
    @(negedge clk);
    n_vec++; if (result_valid !== 1'b0) begin n_err++; $display("FAIL add_pulse: got rv=%b want 0", result_valid); end
  endtask

  task automatic test_digit_limit_chain();
    keys("C99999");
    n_vec++; if (entry_val !== 16'd9999 || disp_char0 !== "9") begin n_err++; $display("FAIL limit_entry: got %0d want 9999", entry_val); end
    keys("*6=");
    n_vec++; if (result_valid !== 1'b1 || result_value !== 16'd59994 || error !== 1'b0) begin n_err++; $display("FAIL chain_first: got rv=%b val=%0d err=%b want 1 59994 0", result_valid, result_value, error); end
    n_vec++; if (entry_val !== 16'd59994) begin n_err++; $display("FAIL chain_entry: got %0d want 59994", entry_val); end
    keys("-3");
    n_vec++; if (op_char !== "-" || entry_val !== 16'd3) begin n_err++; $display("FAIL chain_op: got op=%h entry=%0d want 2d 3", op_char, entry_val); end
    key("=");
    n_vec++; if (result_valid !== 1'b1 || result_value !== 16'd59991) begin n_err++; $display("FAIL chain_second: got rv=%b val=%0d want 1 59991", result_valid, result_value); end
  endtask

  task automatic test_overflow();
    keys("C300*300=");
    n_vec++; if (error !== 1'b1 || result_value !== 16'd0 || result_valid !== 1'b1) begin n_err++; $display("FAIL ovf_err: got err=%b val=%0d rv=%b want 1 0 1", error, result_value, result_valid); end
    keys("5+");
    n_vec++; if (op_char !== "*" || disp_char0 !== "=" || entry_val !== 16'd0 || error !== 1'b1) begin n_err++; $display("FAIL ovf_ignore: got op=%h d0=%h entry=%0d err=%b want 2a 3d 0 1", op_char, disp_char0, entry_val, error); end
    key("C");
    n_vec++; if (error !== 1'b0 || op_char !== 8'h00 || disp_char0 !== 8'h00) begin n_err++; $display("FAIL ovf_clear: got err=%b op=%h d0=%h want 0 00 00", error, op_char, disp_char0); end
    keys("9999+9999*");
    n_vec++; if (op_char !== "+" || entry_val !== 16'd9999) begin n_err++; $display("FAIL op_after_b: got op=%h entry=%0d want 2b 9999", op_char, entry_val); end
  endtask

  task automatic test_errors();
    bit saw_busy;
    keys("C5-9=");
    n_vec++; if (error !== 1'b1 || result_value !== 16'd0 || result_valid !== 1'b1) begin n_err++; $display("FAIL neg_err: got err=%b val=%0d rv=%b want 1 0 1", error, result_value, result_valid); end
    keys("C8/");
    saw_busy = busy;
    keys("0=");
    saw_busy |= busy;
    @(negedge clk);
    saw_busy |= busy;
`ifdef CALC_DIV_EN
    n_vec++; if (error !== 1'b1 || saw_busy !== 1'b0) begin n_err++; $display("FAIL div0_err: got err=%b busy_seen=%b want 1 0", error, saw_busy); end
`else
    n_vec++; if (error !== 1'b0 || op_char !== 8'h00 || entry_val !== 16'd80 || saw_busy !== 1'b0) begin n_err++; $display("FAIL div_ignored: got err=%b op=%h entry=%0d busy_seen=%b want 0 00 80 0", error, op_char, entry_val, saw_busy); end
    n_vec++; if (disp_char0 !== "0" || disp_char1 !== "8") begin n_err++; $display("FAIL div_ignored_disp: got %h %h want 30 38", disp_char0, disp_char1); end
`endif
  endtask

`ifdef CALC_DIV_EN
  task automatic test_divide();
    int  busy_cnt;
    bit  got, saw_rv;
    keys("C1000/7=");
    busy_cnt = 0; got = 0;
    for (int c = 0; c < 40; c++) begin
      if (result_valid) begin got = 1; break; end
      if (busy) busy_cnt++;
      @(negedge clk);
    end
    n_vec++; if (got !== 1'b1 || busy_cnt != 16) begin n_err++; $display("FAIL div_timing: got done=%b busy_cycles=%0d want 1 16", got, busy_cnt); end
    n_vec++; if (result_value !== 16'd142 || error !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL div_result: got %0d err=%b busy=%b want 142 0 0", result_value, error, busy); end
    keys("C1000/7=");
    repeat (5) @(negedge clk);
    key("C");
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL div_abort_busy: got %b want 0", busy); end
    saw_rv = 0;
    repeat (25) begin @(negedge clk); saw_rv |= result_valid; end
    n_vec++; if (saw_rv !== 1'b0 || result_value !== 16'd0) begin n_err++; $display("FAIL div_abort_rv: got rv_seen=%b val=%0d want 0 0", saw_rv, result_value); end
  endtask
`endif

  task automatic test_op_replace();
    keys("C4+-");
    n_vec++; if (op_char !== "-" || disp_char0 !== "-" || disp_char1 !== "+") begin n_err++; $display("FAIL replace_op: got op=%h d0=%h d1=%h want 2d 2d 2b", op_char, disp_char0, disp_char1); end
    key("=");
    n_vec++; if (result_valid !== 1'b0 || disp_char0 !== "-" || op_char !== "-") begin n_err++; $display("FAIL replace_eq_ignored: got rv=%b d0=%h op=%h want 0 2d 2d", result_valid, disp_char0, op_char); end
    keys("2=");
    n_vec++; if (result_valid !== 1'b1 || result_value !== 16'd2) begin n_err++; $display("FAIL replace_result: got rv=%b val=%0d want 1 2", result_valid, result_value); end
    key("7");
    n_vec++; if (op_char !== 8'h00 || entry_val !== 16'd7 || result_value !== 16'd2) begin n_err++; $display("FAIL res_new_a: got op=%h entry=%0d val=%0d want 00 7 2", op_char, entry_val, result_value); end
  endtask

  task automatic test_random();
    logic [7:0] ch;
    int         busy_cnt;
    bit         got;
    key("C");
    model_clear();
    for (int i = 0; i < 400; i++) begin
      ch = rand_key();
      key(ch);
      model_key(ch);
      if (m_div) begin
        busy_cnt = 0; got = 0;
        for (int c = 0; c < 40; c++) begin
          if (result_valid) begin got = 1; break; end
          if (busy) busy_cnt++;
          @(negedge clk);
        end
        n_vec++; if (got !== 1'b1 || busy_cnt != W) begin n_err++; $display("FAIL rnd_div_timing[%0d]: got done=%b busy_cycles=%0d want 1 %0d", i, got, busy_cnt, W); end
        m_rv = 1;
      end
      n_vec++; if (result_valid !== m_rv || error !== m_err) begin n_err++; $display("FAIL rnd_flags[%0d] key %h: got rv=%b err=%b want %b %b", i, ch, result_valid, error, m_rv, m_err); end
      n_vec++; if (result_value !== W'(m_res)) begin n_err++; $display("FAIL rnd_result[%0d] key %h: got %0d want %0d", i, ch, result_value, m_res); end
      n_vec++; if (entry_val !== W'(m_in_res ? m_res : m_acc)) begin n_err++; $display("FAIL rnd_entry[%0d] key %h: got %0d want %0d", i, ch, entry_val, m_in_res ? m_res : m_acc); end
      n_vec++; if (op_char !== m_op || disp_char0 !== m_d0 || disp_char1 !== m_d1) begin n_err++; $display("FAIL rnd_chars[%0d] key %h: got op=%h d0=%h d1=%h want %h %h %h", i, ch, op_char, disp_char0, disp_char1, m_op, m_d0, m_d1); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rnd_busy[%0d]: got %b want 0", i, busy); end
    end
  endtask

  task automatic test_rst_mid_entry();
    keys("C12+3");
    #2 rst = 1'b1;
    #1;
    n_vec++; if (op_char !== 8'h00 || entry_val !== '0 || disp_char0 !== 8'h00 || disp_char1 !== 8'h00) begin n_err++; $display("FAIL rst_async: got op=%h entry=%0d d0=%h d1=%h want all 0", op_char, entry_val, disp_char0, disp_char1); end
    n_vec++; if (result_value !== '0 || result_valid !== 1'b0 || error !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rst_async_flags: got val=%0d rv=%b err=%b busy=%b want 0", result_value, result_valid, error, busy); end
    @(negedge clk);
    rst = 1'b0;
    keys("5+5=");
    n_vec++; if (result_valid !== 1'b1 || result_value !== 16'd10) begin n_err++; $display("FAIL rst_recover: got rv=%b val=%0d want 1 10", result_valid, result_value); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_add();
    test_digit_limit_chain();
    test_overflow();
    test_errors();
`ifdef CALC_DIV_EN
    test_divide();
`endif
    test_op_replace();
    test_random();
    test_rst_mid_entry();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
